// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types for the hazard/forwarding unit: operand select codes and
// the debug state encoding of the stall FSM.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        LU  = 2'd1,
        SB  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle of the hazard unit: stage qualifiers in,
// operand selects and stall/bubble controls out.
interface hazard_fwd_unit_if
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_SRC = 2
);
    logic                             id_valid;
    logic [NUM_SRC-1:0][REG_AW-1:0]   id_rs;
    logic [NUM_SRC-1:0]               id_rs_used;
    logic [REG_AW-1:0]                id_rd;
    logic                             id_wr_en;
    logic                             ex_valid;
    logic                             ex_wr_en;
    logic                             ex_is_load;
    logic [REG_AW-1:0]                ex_rd;
    logic                             mem_valid;
    logic                             mem_wr_en;
    logic [REG_AW-1:0]                mem_rd;
    logic                             lc_issue;
    logic [REG_AW-1:0]                lc_rd;
    logic                             lc_done;
    logic [REG_AW-1:0]                lc_done_rd;
    logic [NUM_SRC-1:0][1:0]          fwd_sel;
    logic                             stall_id;
    logic                             bubble_ex;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_wr_en,
               ex_valid, ex_wr_en, ex_is_load, ex_rd,
               mem_valid, mem_wr_en, mem_rd,
               lc_issue, lc_rd, lc_done, lc_done_rd,
        input  fwd_sel, stall_id, bubble_ex
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_wr_en,
               ex_valid, ex_wr_en, ex_is_load, ex_rd,
               mem_valid, mem_wr_en, mem_rd,
               lc_issue, lc_rd, lc_done, lc_done_rd,
        output fwd_sel, stall_id, bubble_ex
    );

endinterface

// File: rtl/hazard_fwd_unit_scoreboard.sv
// Pending-writeback bits for long-latency destinations, with one hit
// output per read address (sources plus the ID destination).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int NUM_RD = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          set_en,
    input  logic [REG_AW-1:0]             set_addr,
    input  logic                          clr_en,
    input  logic [REG_AW-1:0]             clr_addr,
    input  logic [NUM_RD-1:0][REG_AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]             hit
);

    localparam int NUM_REGS = 1 << REG_AW;

    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] pending_q;

    // Clear is applied before set so a same-cycle reissue keeps the bit owned.
    always_comb begin
        pending_d = pending_q;
        if (clr_en && (clr_addr != '0)) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            pending_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            hit[i] = pending_q[rd_addr[i]];
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// RAW forwarding select, load-use bubble and long-latency scoreboard stall
// for the ID/EX boundary; selects are decided in ID and registered for EX.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pipe_hold,
    hazard_fwd_unit_if.slave   hif,
    output logic [1:0]         hz_state,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [NUM_SRC:0][REG_AW-1:0] sb_addr;
    logic [NUM_SRC:0]             sb_hit_vec;
    logic [NUM_SRC-1:0]           cand;
    logic [NUM_SRC-1:0][1:0]      sel_comb;
    logic                         load_use;
    logic                         sb_hit;
    logic                         stall;

    logic [NUM_SRC-1:0][1:0]      fwd_sel_d;
    logic [NUM_SRC-1:0][1:0]      fwd_sel_q;
    hz_state_e                    state_d;
    hz_state_e                    state_q;
    logic [CNT_W-1:0]             cnt_d;
    logic [CNT_W-1:0]             cnt_q;

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .NUM_RD (NUM_SRC + 1)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (hif.lc_issue),
        .set_addr (hif.lc_rd),
        .clr_en   (hif.lc_done),
        .clr_addr (hif.lc_done_rd),
        .rd_addr  (sb_addr),
        .hit      (sb_hit_vec)
    );

    // A load in EX cannot forward; its consumer falls through to the MEM check next cycle.
    always_comb begin
        cand     = '0;
        sel_comb = '0;
        load_use = 1'b0;
        sb_addr  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i]    = hif.id_rs_used[i] && (hif.id_rs[i] != '0);
            sb_addr[i] = hif.id_rs[i];
            if (cand[i]) begin
                if (hif.ex_valid && hif.ex_wr_en && !hif.ex_is_load &&
                    (hif.ex_rd == hif.id_rs[i])) begin
                    sel_comb[i] = FWD_MEM;
                end else if (hif.mem_valid && hif.mem_wr_en &&
                             (hif.mem_rd == hif.id_rs[i])) begin
                    sel_comb[i] = FWD_WB;
                end
                if (hif.id_valid && hif.ex_valid && hif.ex_is_load &&
                    hif.ex_wr_en && (hif.ex_rd == hif.id_rs[i])) begin
                    load_use = 1'b1;
                end
            end
        end
        sb_addr[NUM_SRC] = hif.id_rd;
    end

    always_comb begin
        sb_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i] && sb_hit_vec[i]) begin
                sb_hit = 1'b1;
            end
        end
        if (hif.id_wr_en && sb_hit_vec[NUM_SRC]) begin
            sb_hit = 1'b1;
        end
        sb_hit = sb_hit && hif.id_valid;
    end

    assign stall         = rst_n && !pipe_hold && (load_use || sb_hit);
    assign hif.stall_id  = stall;
    assign hif.bubble_ex = stall;
    assign hif.fwd_sel   = fwd_sel_q;
    assign hz_state      = state_q;
    assign stall_cnt     = cnt_q;

    always_comb begin
        fwd_sel_d = fwd_sel_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (!pipe_hold) begin
            fwd_sel_d = stall ? '0 : sel_comb;
            if (sb_hit) begin
                state_d = SB;
            end else if ((state_q == RUN) && load_use) begin
                state_d = LU;
            end else begin
                state_d = RUN;
            end
        end
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel_q <= '0;
            state_q   <= RUN;
            cnt_q     <= '0;
        end else begin
            fwd_sel_q <= fwd_sel_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised successor to the combinational RAW-forwarding check. It computes operand-forward selects one cycle early, in ID, and registers them for the instruction entering EX. It also detects load-use hazards and inserts exactly one bubble. A register scoreboard stalls ID on operands or destinations owned by long-latency ops (divider, cache-miss load) until their writeback. It sits between the ID/EX pipeline registers and the EX operand muxes, next to the register file, which is write-first: a same-cycle WB write is visible to an ID read.

## Interface
Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero.
- NUM_SRC, 2, source operands per instruction.
- CNT_W, 32, width of stall performance counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- pipe_hold  in  1  global freeze (downstream not ready).
- id_valid  in  1  ID holds a valid instruction.
- id_rs  in  NUM_SRC×REG_AW  ID source registers.
- id_rs_used  in  NUM_SRC  per-source read enable.
- id_rd  in  REG_AW  ID destination.
- id_wr_en  in  1  ID instruction writes id_rd.
- ex_valid, ex_wr_en, ex_is_load  in  1 each  EX-stage qualifiers.
- ex_rd  in  REG_AW  EX destination.
- mem_valid, mem_wr_en  in  1 each; mem_rd  in  REG_AW  MEM-stage destination.
- lc_issue  in  1; lc_rd  in  REG_AW  long-latency op issued from EX this cycle.
- lc_done  in  1; lc_done_rd  in  REG_AW  long-latency result written this cycle.
- fwd_sel  out  NUM_SRC×2  registered per-operand select for EX.
- stall_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load invalid into ID/EX.
- hz_state  out  2  debug FSM state.
- stall_cnt  out  CNT_W  saturating count of stall_id cycles.

## Operation
- **Forward decision, per source i**, evaluated in ID:
  - The source is a candidate only if id_rs_used[i] and id_rs[i] != 0.
  - EX match (ex_valid & ex_wr_en & !ex_is_load & ex_rd == id_rs[i]) gives FWD_MEM.
  - Otherwise, MEM match (mem_valid & mem_wr_en & mem_rd == id_rs[i]) gives FWD_WB.
  - Otherwise FWD_RF.
  - EX has priority over MEM (newest producer wins).
- **Load-use**: id_valid & candidate source & ex_valid & ex_is_load & ex_wr_en & ex_rd == id_rs[i], with ex_rd != 0.
- **Scoreboard**: pending[2**REG_AW] bits.
  - lc_issue sets pending[lc_rd]; lc_done clears pending[lc_done_rd].
  - Writes to register 0 are ignored.
  - Issue and done on the same register in the same cycle leaves the bit set (the new issue wins).
- **sb_hit**: id_valid & (any candidate source pending, or id_wr_en & pending[id_rd]). The id_rd term covers WAW.
- **stall_id** = !pipe_hold & (load_use | sb_hit), combinational.
- **bubble_ex** = stall_id.
- **fwd_sel register update**:
  - pipe_hold: hold.
  - stall_id: load FWD_RF (bubble).
  - otherwise: load the computed selects.
- **FSM (hz_state)**:
  - RUN=0: load_use → LU=1; sb_hit → SB=2; sb_hit has priority.
  - LU: unconditionally → RUN after one cycle, unless sb_hit → SB.
  - SB: stays while sb_hit; → RUN when clear.
  - pipe_hold freezes the FSM.
- **stall_cnt**: increments on each stall_id cycle and saturates at all-ones.

## Timing
- Reset (rst_n low, asynchronous):
  - fwd_sel = 0 (FWD_RF), pending = 0, hz_state = RUN, stall_cnt = 0.
  - stall_id and bubble_ex are gated to 0 while rst_n is low.
- fwd_sel latency: decided in cycle N in ID, valid in N+1 when the instruction occupies EX.
- Load-use costs exactly one stall cycle:
  - N: stall, load in EX.
  - N+1: load in MEM; ID sees a MEM match and computes FWD_WB.
  - N+2: EX uses the WB value.
- Scoreboard release:
  - A bit set by lc_issue in N is visible to sb_hit in N+1.
  - lc_done in cycle M clears the bit at the M edge; stall_id drops in M+1 and the register file read returns the written value.
- Reset mid-stall: return to RUN immediately and clear all pending bits. Surrounding pipeline flush is the core's responsibility.
- pipe_hold overrides stall_id to 0. The scoreboard still updates during hold.

## Structure
- hazard_pkg:
  - fwd_sel_e: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - hz_state_e: RUN, LU, SB.
  - Shared REG_AW default.
- Sub-module hazard_scoreboard: pending bit array with set/clear ports, an NUM_SRC+1 read-port hit vector, and same-cycle set-priority.
- Top: forward compare loop over NUM_SRC, FSM, counter.

## Test plan
- **ALU back-to-back**: EX writes x5 (non-load), ID reads rs1=x5 → next cycle fwd_sel[0]=FWD_MEM, no stall.
- **Double producer**: EX writes x7 and MEM writes x7, ID reads rs2=x7 → fwd_sel[1]=FWD_MEM. With only MEM writing x7 → FWD_WB. rs=x0 with all stages writing x0 → FWD_RF.
- **Load-use**: EX load to x3, ID reads x3 → stall_id=1 for one cycle, hz_state LU, then fwd_sel=FWD_WB; stall_cnt=1.
- **Scoreboard**:
  - lc_issue x9, then ID reads x9 → stall until lc_done x9 at cycle M; stall_id=0 at M+1.
  - Concurrent lc_issue/lc_done on x9 → stays pending.
  - A WAW write to x9 while pending also stalls.
- **Hold and reset**: pipe_hold during load-use → stall_id=0 and fwd_sel/FSM frozen. Asserting rst_n=0 in SB state → pending cleared, RUN, outputs 0 asynchronously.
